// File: rtl/library_ureg_if.sv
// Bus of the universal register cell: control, data and serial inputs plus the
// register outputs. The clock and clear stay outside as plain ports.
interface library_ureg_if #(
  parameter int WIDTH = 4
);
  logic             iPre;
  logic             iEnb;
  logic             iSel;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [2:0]       iMode;
  logic             iSerL;
  logic             iSerR;
  logic [WIDTH-1:0] oQ;
  logic [WIDTH-1:0] oQn;
  logic             oSer;
  logic             oTc;

  modport master (
    output iPre, iEnb, iSel, iA, iB, iMode, iSerL, iSerR,
    input  oQ, oQn, oSer, oTc
  );

  modport slave (
    input  iPre, iEnb, iSel, iA, iB, iMode, iSerL, iSerR,
    output oQ, oQn, oSer, oTc
  );
endinterface

// File: rtl/library_ureg.sv
// WIDTH-bit universal register: hold, load, shift, rotate, count up/down and
// invert, with async clear, sync preset, active-low enable and terminal count.
module library_ureg #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input logic            iClk,
  input logic            iClr,
  library_ureg_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_UP    = 3'b100,
    MODE_DOWN  = 3'b101,
    MODE_ROL   = 3'b110,
    MODE_INV   = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  mode_e            mode;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  assign mode = mode_e'(bus.iMode);

  // Preset overrides the enable; a disabled cell simply holds.
  always_comb begin
    q_next = q_reg;
    if (!bus.iPre) begin
      q_next = PRESET_VAL;
    end else if (!bus.iEnb) begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_LOAD: q_next = bus.iSel ? bus.iB : bus.iA;
        MODE_SHL:  q_next = {q_reg[WIDTH-2:0], bus.iSerL};
        MODE_SHR:  q_next = {bus.iSerR, q_reg[WIDTH-1:1]};
        MODE_UP:   q_next = q_reg + ONE;
        MODE_DOWN: q_next = q_reg - ONE;
        MODE_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        MODE_INV:  q_next = ~q_reg;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  // All outputs derive from the single state register, so oQn can never skew from oQ.
  assign bus.oQ   = q_reg;
  assign bus.oQn  = ~q_reg;
  assign bus.oSer = (mode == MODE_SHL || mode == MODE_ROL) ? q_reg[WIDTH-1] : q_reg[0];
  assign bus.oTc  = ((mode == MODE_UP)   && (q_reg == ALL_ONES)) ||
                    ((mode == MODE_DOWN) && (q_reg == '0));

endmodule

// File: tb/tb_library_ureg.sv
// Self-checking bench for library_ureg: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_library_ureg;

  localparam int WIDTH = 4;
  localparam int M     = 16;
  localparam int PRE   = 15;

  logic iClk;
  logic iClr;
  int   checkCount = 0;
  int   errorCount = 0;
  bit   checkEn    = 0;
  int   mq;

  library_ureg_if #(.WIDTH(WIDTH)) bus ();

  library_ureg #(.WIDTH(WIDTH), .PRESET_VAL(4'hF)) dut (
    .iClk (iClk),
    .iClr (iClr),
    .bus  (bus.slave)
  );

  initial begin
    iClk = 1'b0;
    forever #35 iClk = ~iClk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: register value as a plain integer modulo 2^WIDTH.
  always @(posedge iClk or negedge iClr) begin
    if (!iClr) mq = 0;
    else if (!bus.iPre) mq = PRE;
    else if (!bus.iEnb) begin
      case (bus.iMode)
        3'd0: mq = mq;
        3'd1: mq = bus.iSel ? int'(bus.iB) : int'(bus.iA);
        3'd2: mq = (mq * 2 + int'(bus.iSerL)) % M;
        3'd3: mq = mq / 2 + int'(bus.iSerR) * (M / 2);
        3'd4: mq = (mq + 1) % M;
        3'd5: mq = (mq + M - 1) % M;
        3'd6: mq = (mq * 2) % M + mq / (M / 2);
        default: mq = M - 1 - mq;
      endcase
    end
  end

  // Every cycle, mid-period, the DUT outputs must agree with the model.
  always @(negedge iClk) begin
    if (checkEn) begin
      checkOutput("model_q",   32'(bus.oQ),  32'(mq));
      checkOutput("model_qn",  32'(bus.oQn), 32'(M - 1 - mq));
      checkOutput("model_ser", 32'(bus.oSer),
                  32'((bus.iMode == 3'd2 || bus.iMode == 3'd6) ? mq / (M / 2) : mq % 2));
      checkOutput("model_tc",  32'(bus.oTc),
                  32'((bus.iMode == 3'd4 && mq == M - 1) || (bus.iMode == 3'd5 && mq == 0)));
    end
  end

  task automatic applyStimulus(input logic [2:0] mode, input logic enb, input logic pre,
                               input logic sel, input logic [3:0] a, input logic [3:0] b,
                               input logic serL, input logic serR);
    bus.iMode = mode;
    bus.iEnb  = enb;
    bus.iPre  = pre;
    bus.iSel  = sel;
    bus.iA    = a;
    bus.iB    = b;
    bus.iSerL = serL;
    bus.iSerR = serR;
  endtask

  task automatic tick();
    @(posedge iClk);
    #10;
  endtask

  task automatic loadValue(input logic [3:0] v);
    applyStimulus(3'd1, 1'b0, 1'b1, 1'b0, v, 4'h0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    iClr = 1'b1;
    applyStimulus(3'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    #1 iClr = 1'b0;
    #2;
    checkOutput("clr_async_q",  32'(bus.oQ),  32'h0);
    checkOutput("clr_async_qn", 32'(bus.oQn), 32'hF);
    checkEn = 1;
    @(posedge iClk);
    @(posedge iClk);
    #10;
    checkOutput("clr_held_q",   32'(bus.oQ),   32'h0);
    checkOutput("clr_held_ser", 32'(bus.oSer), 32'h0);
    iClr = 1'b1;

    applyStimulus(3'd1, 1'b0, 1'b1, 1'b0, 4'h5, 4'hA, 1'b0, 1'b0);
    tick();
    checkOutput("load_a", 32'(bus.oQ), 32'h5);
    bus.iSel = 1'b1;
    tick();
    checkOutput("load_b", 32'(bus.oQ), 32'hA);
    bus.iEnb = 1'b1;
    bus.iA   = 4'h3;
    tick();
    bus.iA   = 4'h7;
    tick();
    checkOutput("enb_hold", 32'(bus.oQ), 32'hA);

    loadValue(4'hE);
    applyStimulus(3'd4, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("up_tc_E", 32'(bus.oTc), 32'h0);
    tick();
    checkOutput("up_F",    32'(bus.oQ),  32'hF);
    checkOutput("up_tc_F", 32'(bus.oTc), 32'h1);
    tick();
    checkOutput("up_wrap", 32'(bus.oQ),  32'h0);
    bus.iMode = 3'd5;
    #1;
    checkOutput("dn_tc_0", 32'(bus.oTc), 32'h1);
    tick();
    checkOutput("dn_wrap", 32'(bus.oQ),  32'hF);
    checkOutput("dn_tc_F", 32'(bus.oTc), 32'h0);

    loadValue(4'h9);
    applyStimulus(3'd2, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("shl",     32'(bus.oQ),   32'h3);
    checkOutput("shl_ser", 32'(bus.oSer), 32'h0);
    loadValue(4'h9);
    applyStimulus(3'd6, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("rol", 32'(bus.oQ), 32'h3);
    loadValue(4'h9);
    applyStimulus(3'd3, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("shr",     32'(bus.oQ),   32'hC);
    checkOutput("shr_ser", 32'(bus.oSer), 32'h0);

    applyStimulus(3'd7, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("preset", 32'(bus.oQ), 32'hF);
    applyStimulus(3'd7, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("invert", 32'(bus.oQ), 32'h0);

    // Every mode once from 0110 with both serial inputs opposite; the model checks.
    for (int m = 0; m < 8; m++) begin
      loadValue(4'h6);
      applyStimulus(3'(m), 1'b0, 1'b1, 1'b1, 4'h2, 4'hD, 1'b1, 1'b0);
      tick();
      tick();
    end

    loadValue(4'h3);
    applyStimulus(3'd4, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("cnt_4", 32'(bus.oQ), 32'h4);
    iClr = 1'b0;
    #1;
    checkOutput("cnt_clr_async", 32'(bus.oQ), 32'h0);
    tick();
    checkOutput("cnt_clr_held", 32'(bus.oQ), 32'h0);
    iClr = 1'b1;
    tick();
    checkOutput("cnt_1", 32'(bus.oQ), 32'h1);
    tick();
    checkOutput("cnt_2", 32'(bus.oQ), 32'h2);
    tick();
    checkOutput("cnt_3", 32'(bus.oQ), 32'h3);

    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
